// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one external memory bus between instruction fetch and the data
//   (MEM stage) port. One transfer at a time is sequenced by a small FSM. All
//   bus outputs, returned data, acks and the error pulse are registered. A
//   combinational stall request is raised while a requester is still waiting.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   if_*           fetch requester: req/addr in, data/ack out
//   d_*            data requester: req/we/sel/addr/wdata in, rdata/ack out
//   flush_i        pipeline flush, cancels a fetch in flight
//   bus_*          memory bus master side: stb/we/sel/addr/wdata out,
//                  rdata/ack in
//   stallreq_o     stall request toward pipeline control
//   bus_err_o      one-cycle pulse when a transfer is aborted by timeout
//
// States
//   state  | meaning
//   IDLE   | no transfer outstanding, bus strobe low
//   D_BUSY | data access on the bus, waiting for bus_ack_i
//   I_BUSY | fetch on the bus, waiting for bus_ack_i
//   I_DROP | fetch cancelled by flush, strobe held until the bus finishes
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_ack_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ack_o,
    input  logic                flush_i,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_o,
    output logic                bus_err_o
);

    localparam int SEL_W = DATA_W / 8;
    // Wide enough to hold TIMEOUT itself; at least one bit when TIMEOUT is 0.
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2,
        I_DROP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              timeout_hit;
    logic              d_take, i_take;

    logic              stb_nxt, we_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] if_data_nxt, d_rdata_nxt;
    logic              if_ack_nxt, d_ack_nxt, err_nxt;

    // A requester still holding req during its ack cycle has already been
    // served; ignoring it there prevents a duplicate transfer.
    assign d_take = d_req_i & ~d_ack_o;
    assign i_take = if_req_i & ~if_ack_o & ~flush_i;

    // The cycle that would bring the counter to TIMEOUT aborts the transfer.
    assign timeout_hit = (TIMEOUT != 0) && !bus_ack_i
                         && (CNT_W'(wait_cnt + 1'b1) == CNT_TC);

    assign stallreq_o = (d_req_i & ~d_ack_o) | (if_req_i & ~if_ack_o & ~flush_i);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            d_rdata_o   <= '0;
            d_ack_o     <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            bus_stb_o   <= stb_nxt;
            bus_we_o    <= we_nxt;
            bus_sel_o   <= sel_nxt;
            bus_addr_o  <= addr_nxt;
            bus_wdata_o <= wdata_nxt;
            if_data_o   <= if_data_nxt;
            if_ack_o    <= if_ack_nxt;
            d_rdata_o   <= d_rdata_nxt;
            d_ack_o     <= d_ack_nxt;
            bus_err_o   <= err_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_take)
                    state_nxt = D_BUSY;
                else if (i_take)
                    state_nxt = I_BUSY;
            end
            D_BUSY: begin
                if (bus_ack_i || timeout_hit)
                    state_nxt = IDLE;
            end
            I_BUSY: begin
                // A timeout coinciding with a flush still ends the transfer
                // rather than parking in I_DROP with the strobe up.
                if (bus_ack_i || timeout_hit)
                    state_nxt = IDLE;
                else if (flush_i)
                    state_nxt = I_DROP;
            end
            I_DROP: begin
                if (bus_ack_i || timeout_hit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the wait counter
    always_comb begin
        stb_nxt     = bus_stb_o;
        we_nxt      = bus_we_o;
        sel_nxt     = bus_sel_o;
        addr_nxt    = bus_addr_o;
        wdata_nxt   = bus_wdata_o;
        if_data_nxt = if_data_o;
        d_rdata_nxt = d_rdata_o;
        if_ack_nxt  = 1'b0;
        d_ack_nxt   = 1'b0;
        err_nxt     = 1'b0;

        // I_BUSY -> I_DROP keeps counting so a cancelled fetch still times out.
        if (state == IDLE || state_nxt == IDLE)
            wait_cnt_nxt = '0;
        else if (!bus_ack_i)
            wait_cnt_nxt = CNT_W'(wait_cnt + 1'b1);
        else
            wait_cnt_nxt = wait_cnt;

        case (state)
            IDLE: begin
                if (d_take) begin
                    stb_nxt   = 1'b1;
                    we_nxt    = d_we_i;
                    sel_nxt   = d_sel_i;
                    addr_nxt  = d_addr_i;
                    wdata_nxt = d_wdata_i;
                end else if (i_take) begin
                    stb_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    sel_nxt   = '1;
                    addr_nxt  = if_addr_i;
                    wdata_nxt = '0;
                end
            end
            D_BUSY: begin
                if (bus_ack_i) begin
                    stb_nxt     = 1'b0;
                    d_ack_nxt   = 1'b1;
                    d_rdata_nxt = bus_rdata_i;
                end else if (timeout_hit) begin
                    stb_nxt     = 1'b0;
                    err_nxt     = 1'b1;
                    d_ack_nxt   = 1'b1;
                    d_rdata_nxt = '0;
                end
            end
            I_BUSY: begin
                if (bus_ack_i) begin
                    stb_nxt = 1'b0;
                    if (!flush_i) begin
                        if_ack_nxt  = 1'b1;
                        if_data_nxt = bus_rdata_i;
                    end
                end else if (timeout_hit) begin
                    stb_nxt = 1'b0;
                    err_nxt = 1'b1;
                    if (!flush_i) begin
                        if_ack_nxt  = 1'b1;
                        if_data_nxt = '0;
                    end
                end
            end
            I_DROP: begin
                if (bus_ack_i) begin
                    stb_nxt = 1'b0;
                end else if (timeout_hit) begin
                    stb_nxt = 1'b0;
                    err_nxt = 1'b1;
                end
            end
            default: stb_nxt = 1'b0;
        endcase
    end

endmodule
